iter_mult_radix: RTL



---
 rtl/iter_mult_pkg.sv | 37 +++
 rtl/iter_mult_pp.sv | 33 +++
 rtl/iter_mult_radix.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/iter_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_pkg
// Purpose  : Shared defaults, FSM state encoding and sizing helpers for the
//            digit-serial iterative multiplier (iter_mult_radix).
// Contents : DEF_DATA_WIDTH / DEF_DIGIT_WIDTH  default operand / digit widths
//            state_t                           IDLE / CALC / DONE encoding
//            calc_num_iter()                   iterations per operation
//            calc_cnt_width()                  iteration counter width
// Revision : 1.0 - initial release
// ============================================================================
package iter_mult_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DIGIT_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One iteration retires one digit of operand b.
  function automatic int calc_num_iter(input int data_w, input int digit_w);
    return data_w / digit_w;
  endfunction

  // Counter only needs to reach NUM_ITER-1; keep at least one bit so the
  // single-iteration configuration still has a legal vector.
  function automatic int calc_cnt_width(input int data_w, input int digit_w);
    int n;
    n = data_w / digit_w;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : iter_mult_pkg
`default_nettype wire

// File: rtl/iter_mult_pp.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_pp
// Purpose  : Combinational partial-product generator: magnitude of operand a
//            times one unsigned digit of operand b. Kept separate so a
//            recoded (e.g. Booth) digit scheme only touches this block.
// Ports    : i_mcand  [DATA_WIDTH-1:0]              |a|
//            i_digit  [DIGIT_WIDTH-1:0]             current digit of |b|
//            o_pp     [DATA_WIDTH+DIGIT_WIDTH-1:0]  i_mcand * i_digit
// Revision : 1.0 - initial release
// ============================================================================
module iter_mult_pp #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0]             i_mcand,
  input  logic [DIGIT_WIDTH-1:0]            i_digit,
  output logic [DATA_WIDTH+DIGIT_WIDTH-1:0] o_pp
);

  localparam int c_pp_w = DATA_WIDTH + DIGIT_WIDTH;

  logic [c_pp_w-1:0] w_mcand_ext;
  logic [c_pp_w-1:0] w_digit_ext;

  // Both factors are unsigned magnitudes; zero-extend to the full product
  // width so the multiply cannot truncate.
  assign w_mcand_ext = c_pp_w'(i_mcand);
  assign w_digit_ext = c_pp_w'(i_digit);
  assign o_pp        = w_mcand_ext * w_digit_ext;

endmodule : iter_mult_pp
`default_nettype wire

// File: rtl/iter_mult_radix.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_radix
// Purpose  : Iterative multiplier retiring DIGIT_WIDTH bits of b per cycle,
//            with per-operation signed/unsigned select, multiply-accumulate
//            and abort. start/busy/finish handshake.
// Ports    : clk_i         rising-edge clock
//            rst_i         asynchronous active-high reset
//            start_i       start request (sampled in IDLE only)
//            signed_i      1 = two's-complement operands (sampled with start)
//            accumulate_i  1 = add product to outdata_r_o (sampled with start)
//            abort_i       cancel the running operation (CALC only)
//            indata_a_i    operand a [DATA_WIDTH]
//            indata_b_i    operand b [DATA_WIDTH]
//            busy_o        operation in progress
//            finish_o      one-cycle pulse, outdata_r_o just updated
//            outdata_r_o   result / accumulator [2*DATA_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module iter_mult_radix
  import iter_mult_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DIGIT_WIDTH = DEF_DIGIT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    signed_i,
  input  logic                    accumulate_i,
  input  logic                    abort_i,
  input  logic [DATA_WIDTH-1:0]   indata_a_i,
  input  logic [DATA_WIDTH-1:0]   indata_b_i,
  output logic                    busy_o,
  output logic                    finish_o,
  output logic [2*DATA_WIDTH-1:0] outdata_r_o
);

  localparam int c_num_iter = calc_num_iter(DATA_WIDTH, DIGIT_WIDTH);
  localparam int c_cnt_w    = calc_cnt_width(DATA_WIDTH, DIGIT_WIDTH);
  localparam int c_prod_w   = 2 * DATA_WIDTH;
  localparam int c_pp_w     = DATA_WIDTH + DIGIT_WIDTH;
  // Largest shift is DATA_WIDTH-DIGIT_WIDTH, always below 2^c_sh_w.
  localparam int c_sh_w     = $clog2(DATA_WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_num_iter - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter check
  // --------------------------------------------------------------------------
  if ((DIGIT_WIDTH < 1) || (DIGIT_WIDTH > DATA_WIDTH) ||
      ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_bad_digit_width
    $error("iter_mult_radix: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_abs_a;
  logic [DATA_WIDTH-1:0] r_b_rem;     // |b|, shifted right one digit per cycle
  logic                  r_neg;
  logic                  r_acc;
  logic [c_prod_w-1:0]   r_partial;
  logic                  r_busy;
  logic                  r_finish;
  logic [c_prod_w-1:0]   r_out;

  // --------------------------------------------------------------------------
  // Operand conditioning (used only in the start cycle)
  // --------------------------------------------------------------------------
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;

  assign w_a_neg = signed_i & indata_a_i[DATA_WIDTH-1];
  assign w_b_neg = signed_i & indata_b_i[DATA_WIDTH-1];
  // Negating the most negative value wraps back onto itself, which read as
  // unsigned is exactly its magnitude 2^(W-1), so no extra bit is needed.
  assign w_abs_a = w_a_neg ? (-indata_a_i) : indata_a_i;
  assign w_abs_b = w_b_neg ? (-indata_b_i) : indata_b_i;

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic [c_pp_w-1:0]   w_pp;
  logic [c_prod_w-1:0] w_pp_ext;
  logic [c_sh_w-1:0]   w_shamt;
  logic [c_prod_w-1:0] w_sum;
  logic [c_prod_w-1:0] w_prod;
  logic [c_prod_w-1:0] w_out_next;
  logic                w_last_iter;

  iter_mult_pp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DIGIT_WIDTH (DIGIT_WIDTH)
  ) u_pp (
    .i_mcand (r_abs_a),
    .i_digit (r_b_rem[DIGIT_WIDTH-1:0]),
    .o_pp    (w_pp)
  );

  assign w_pp_ext    = c_prod_w'(w_pp);
  assign w_shamt     = c_sh_w'(r_cnt) * c_sh_w'(DIGIT_WIDTH);
  assign w_sum       = r_partial + (w_pp_ext << w_shamt);
  assign w_last_iter = (r_cnt == c_last_cnt);

  // The final sign fix-up and accumulate are taken from the last iteration's
  // sum so the result register loads on the edge that enters DONE, which is
  // the same edge that raises finish_o.
  assign w_prod      = r_neg ? (-w_sum) : w_sum;
  assign w_out_next  = r_acc ? (r_out + w_prod) : w_prod;

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_abs_a   <= '0;
      r_b_rem   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= 1'b0;
      r_partial <= '0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_out     <= '0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          // abort_i is deliberately not looked at here: start wins.
          if (start_i) begin
            r_abs_a   <= w_abs_a;
            r_b_rem   <= w_abs_b;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_acc     <= accumulate_i;
            r_partial <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= CALC;
          end
        end

        CALC: begin
          if (abort_i) begin
            // Drop the operation; the accumulator keeps its old value.
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_partial <= w_sum;
            r_cnt     <= r_cnt + c_cnt_w'(1);
            r_b_rem   <= r_b_rem >> DIGIT_WIDTH;
            if (w_last_iter) begin
              r_out    <= w_out_next;
              r_finish <= 1'b1;
              r_state  <= DONE;
            end
          end
        end

        DONE: begin
          // Single result cycle; start_i and abort_i are ignored here.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign finish_o    = r_finish;
  assign outdata_r_o = r_out;

endmodule : iter_mult_radix
`default_nettype wire
